// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter (uart_tx_arb, rr_pick).
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int GRANT_W = 3;

  // Position reached by stepping `step` places past `base` on a ring of `n` slots.
  function automatic int wrap_inc(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin search, starting one place after last_grant.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == wrap_inc(int'(last_grant), k, N_REQ))) begin
          found = 1'b1;
          idx   = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one UART transmitter between N_REQ byte sources.
// Optional packet lock (requester keeps the UART until req_last) under `define UART_ARB_LOCK_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*8-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 uart_tx_valid,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_complete,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy
);

  arb_state_t         state;
  arb_state_t         next_state;
  logic [GRANT_W-1:0] last_grant;
  logic [N_REQ-1:0]   cand;
  logic               found;
  logic [GRANT_W-1:0] pick_idx;
  logic               take;
  logic [7:0]         sel_data;

`ifdef UART_ARB_LOCK_EN
  logic               lock;
  logic [GRANT_W-1:0] lock_id;
  logic               sel_last;

  // While a packet is open only its owner may compete.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = req_valid[i] && (!lock || (lock_id == GRANT_W'(i)));
    end
  end

  always_comb begin
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == GRANT_W'(i)) sel_last = req_last[i];
    end
  end
`else
  logic unused_last;

  assign cand        = req_valid;
  assign unused_last = ^req_last;
`endif

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req       (cand),
    .last_grant(last_grant),
    .found     (found),
    .idx       (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == GRANT_W'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (!reset && found) begin
          take       = 1'b1;
          next_state = SEND;
          for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (pick_idx == GRANT_W'(i));
          end
        end
      end
      SEND: begin
        if (uart_tx_complete) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= 8'h00;
      grant_id      <= '0;
      last_grant    <= GRANT_W'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock          <= 1'b0;
      lock_id       <= '0;
`endif
    end else begin
      state <= next_state;
      if (take) begin
        uart_tx_data  <= sel_data;
        grant_id      <= pick_idx;
        last_grant    <= pick_idx;
        uart_tx_valid <= 1'b1;
`ifdef UART_ARB_LOCK_EN
        lock          <= !sel_last;
        lock_id       <= pick_idx;
`endif
      end else if (state == SEND && uart_tx_complete) begin
        // Dropped in the stop bit so the UART never re-sends this byte.
        uart_tx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb (N_REQ=4) with a tx_complete stub 10 cycles after tx_valid rises.
module tb_uart_tx_arb;

  localparam int N = 4;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           uart_tx_valid;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_complete;
  logic [2:0]     grant_id;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] src_q [N][$];
  exp_t       exp_q [$];
  int         ready_cnt [N];

  logic [N-1:0] acc;
  logic         prev_v;
  logic         fire;
  logic [7:0]   held;
  int           cnt;

  uart_tx_arb #(
    .N_REQ(N)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .uart_tx_valid   (uart_tx_valid),
    .uart_tx_data    (uart_tx_data),
    .uart_tx_complete(uart_tx_complete),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic last);
    src_q[i].push_back({last, d});
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 3'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clock);
      done = (exp_q.size() == 0) && !busy && !uart_tx_valid;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    if (!done) check({tag, "_drain_timeout"}, 0, 1);
  endtask

  // Bus model: requester queues, scoreboard compare on tx_valid rise, tx_complete stub.
  initial begin : bfm
    req_valid        = '0;
    req_data         = '0;
    req_last         = '0;
    uart_tx_complete = 1'b0;
    prev_v           = 1'b0;
    cnt              = 0;
    held             = '0;
    forever begin
      @(negedge clock);
      acc = req_valid & req_ready;
      check("ready_onehot", 32'($onehot0(req_ready)), 1);
      for (int i = 0; i < N; i++) if (acc[i]) ready_cnt[i]++;
      fire = 1'b0;
      if (reset) begin
        cnt    = 0;
        prev_v = 1'b0;
      end else begin
        if (cnt == 1) fire = 1'b1;
        if (cnt > 0) cnt--;
        if (uart_tx_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant_id", grant_id, e.id);
            check("tx_data", uart_tx_data, e.data);
          end
          held = uart_tx_data;
          cnt  = 10;
        end else if (uart_tx_valid) begin
          check("tx_hold", uart_tx_data, held);
        end
        prev_v = uart_tx_valid;
      end
      @(posedge clock); #1;
      uart_tx_complete = fire;
      for (int i = 0; i < N; i++) begin
        logic [8:0] item;
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        item                 = (src_q[i].size() != 0) ? src_q[i][0] : 9'h0;
        req_valid[i]         = (src_q[i].size() != 0);
        req_data[8*i +: 8]   = item[7:0];
        req_last[i]          = item[8];
      end
    end
  end

  initial begin : main
    reset = 1'b1;

    // 1: idle after reset
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("t1_tx_valid", uart_tx_valid, 0);
      check("t1_ready", req_ready, 0);
      check("t1_grant_id", grant_id, 0);
      check("t1_busy", busy, 0);
    end

    // 2: single requester, back-to-back bytes
    do_reset();
    push_src(0, 8'h41, 1'b1); push_src(0, 8'h42, 1'b1);
    push_exp(0, 8'h41); push_exp(0, 8'h42);
    drain("t2");
    check("t2_ready0", ready_cnt[0], 2);

    // 3: two always-valid requesters alternate
    do_reset();
    push_src(0, 8'hAA, 1'b1); push_src(0, 8'hAA, 1'b1);
    push_src(1, 8'h55, 1'b1); push_src(1, 8'h55, 1'b1);
    push_exp(0, 8'hAA); push_exp(1, 8'h55); push_exp(0, 8'hAA); push_exp(1, 8'h55);
    drain("t3");
    check("t3_ready0", ready_cnt[0], 2);
    check("t3_ready1", ready_cnt[1], 2);

    // 4: pointer at 3 after reset, req1 and req2 valid -> 1 then 2
    do_reset();
    push_src(1, 8'h11, 1'b1); push_src(2, 8'h22, 1'b1);
    push_exp(1, 8'h11); push_exp(2, 8'h22);
    drain("t4");
    check("t4_ready1", ready_cnt[1], 1);
    check("t4_ready2", ready_cnt[2], 1);

    // 5: reset mid-SEND abandons the byte and restarts from requester 0
    do_reset();
    push_src(0, 8'h77, 1'b1); push_src(0, 8'h78, 1'b1);
    push_exp(0, 8'h77); push_exp(0, 8'h78); push_exp(1, 8'h99);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clock);
        seen = busy;
      end
      check("t5_busy_seen", seen, 1);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    push_src(1, 8'h99, 1'b1);
    @(negedge clock);
    check("t5_ready_in_reset", req_ready, 0);
    @(negedge clock);
    check("t5_tx_valid_reset", uart_tx_valid, 0);
    check("t5_busy_reset", busy, 0);
    check("t5_grant_reset", grant_id, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    drain("t5");
    check("t5_ready0", ready_cnt[0], 2);
    check("t5_ready1", ready_cnt[1], 1);

    // 6: packet lock (macro) versus per-byte interleave
    do_reset();
    push_src(0, 8'h01, 1'b0); push_src(0, 8'h02, 1'b0); push_src(0, 8'h03, 1'b1);
    push_src(1, 8'hA1, 1'b1); push_src(1, 8'hA2, 1'b1);
`ifdef UART_ARB_LOCK_EN
    push_exp(0, 8'h01); push_exp(0, 8'h02); push_exp(0, 8'h03);
    push_exp(1, 8'hA1); push_exp(1, 8'hA2);
`else
    push_exp(0, 8'h01); push_exp(1, 8'hA1); push_exp(0, 8'h02);
    push_exp(1, 8'hA2); push_exp(0, 8'h03);
`endif
    drain("t6");
    check("t6_ready0", ready_cnt[0], 3);
    check("t6_ready1", ready_cnt[1], 2);
    check("t6_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
